// File: rtl/nios_i2c_acc_sample_seq.sv
// rtl/nios_i2c_acc_sample_seq.sv - ADXL345 sample sequencer: six I2C byte reads per tick, XYZ words into a FIFO
module nios_i2c_acc_sample_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h53,
  parameter logic [7:0] DATA_REG   = 8'h32,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [6:0]  req_dev,
  output logic [7:0]  req_reg,
  input  logic        resp_valid,
  input  logic [7:0]  resp_data,
  input  logic        resp_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] PUSH_MAX = LW'(FIFO_DEPTH - 3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [39:0]     bytes_q;
  logic            tick_q;
  logic            enable_q, irq_en_q;
  logic            overflow_q, err_q, missed_q;
  logic [15:0]     mem_q [0:FIFO_DEPTH-1];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     readdata_q, rd_mux;

  logic tick_edge, reg_wr, status_clr, start_req;
  logic sample_done, sample_fail, byte_ok;
  logic push, drop, pop, nonempty, busy;
  logic [15:0] word_x, word_y, word_z;
  logic unused_wdata;

  assign unused_wdata = ^writedata[15:3];

  assign tick_edge  = tick & ~tick_q;
  assign reg_wr     = chipselect & ~write_n;
  assign status_clr = reg_wr & (address == 3'd0);
  assign start_req  = (tick_edge & enable_q) | (reg_wr & (address == 3'd1) & writedata[2]);
  assign busy       = (state_q != S_IDLE);
  assign nonempty   = (level_q != '0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sample_done = 1'b0;
    sample_fail = 1'b0;
    byte_ok     = 1'b0;
    case (state_q)
      S_IDLE: if (start_req) begin
        state_d = S_REQ;
        idx_d   = 3'd0;
      end
      S_REQ: if (req_ready) state_d = S_WAIT;
      S_WAIT: if (resp_valid) begin
        if (resp_err) begin
          state_d     = S_IDLE;
          idx_d       = 3'd0;
          sample_fail = 1'b1;
        end else if (idx_q == 3'd5) begin
          state_d     = S_IDLE;
          idx_d       = 3'd0;
          sample_done = 1'b1;
        end else begin
          state_d = S_REQ;
          idx_d   = idx_q + 3'd1;
          byte_ok = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_valid = (state_q == S_REQ);
  assign req_dev   = DEV_ADDR;
  assign req_reg   = DATA_REG + {5'b0, idx_q};

  // Bytes 0..4 shift in from the top; byte 5 is taken straight from resp_data at push time.
  assign word_x = bytes_q[15:0];
  assign word_y = bytes_q[31:16];
  assign word_z = {resp_data, bytes_q[39:32]};

  // Room is judged on the pre-pop level so a same-cycle pop never admits a push that would not fit.
  assign push    = sample_done & (level_q <= PUSH_MAX);
  assign drop    = sample_done & ~(level_q <= PUSH_MAX);
  assign pop     = chipselect & read & (address == 3'd2) & nonempty;
  assign level_d = level_q + (push ? LW'(3) : LW'(0)) - (pop ? LW'(1) : LW'(0));

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0: rd_mux = {11'b0, missed_q, err_q, busy, overflow_q, nonempty};
      3'd1: rd_mux = {14'b0, irq_en_q, enable_q};
      3'd2: rd_mux = nonempty ? mem_q[rd_ptr_q] : 16'h0000;
      3'd3: rd_mux = {{(16 - LW){1'b0}}, level_q};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      bytes_q    <= '0;
      tick_q     <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      missed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      readdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick;
      if (byte_ok) bytes_q <= {resp_data, bytes_q[39:8]};
      if (reg_wr && address == 3'd1) begin
        enable_q <= writedata[0];
        irq_en_q <= writedata[1];
      end
      overflow_q <= (overflow_q & ~status_clr) | drop;
      err_q      <= (err_q & ~status_clr) | sample_fail;
      missed_q   <= (missed_q & ~status_clr) | (start_req & busy);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(3);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      if (chipselect && read) readdata_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]          <= word_x;
      mem_q[wr_ptr_q + PW'(1)] <= word_y;
      mem_q[wr_ptr_q + PW'(2)] <= word_z;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_en_q & ((level_q >= LW'(3)) | overflow_q | err_q);

endmodule

// File: tb/tb_nios_i2c_acc_sample_seq.sv
// tb/tb_nios_i2c_acc_sample_seq.sv - randomized scoreboard bench for the accelerometer sample sequencer
module tb_nios_i2c_acc_sample_seq;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read = 1'b0;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        resp_err = 1'b0;

  always #5 clk = ~clk;

  nios_i2c_acc_sample_seq #(.DEV_ADDR(7'h53), .DATA_REG(8'h32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .address(address), .chipselect(chipselect), .write_n(write_n), .read(read),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev), .req_reg(req_reg),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue of words, plus flag and ctrl bits.
  logic [15:0] model_q [$];
  bit m_ovf, m_err, m_missed, m_en, m_irq_en;

  logic [7:0]  exp_req_q [$];
  logic [15:0] exp_rd_q [$];
  string       exp_rd_name [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  function automatic logic [15:0] exp_status();
    return {11'b0, m_missed, m_err, 1'b0, m_ovf, model_q.size() != 0};
  endfunction

  initial begin : monitor
    bit rd_pend = 1'b0;
    bit prev_hold = 1'b0;
    logic [7:0] prev_reg = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rd_pend) begin
        if (exp_rd_q.size() == 0) fail_event("rd_unexpected");
        else chk(exp_rd_name.pop_front(), readdata, exp_rd_q.pop_front());
      end
      rd_pend = chipselect && read;
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("req_valid_held", req_valid, 1);
          chk("req_reg_stable", req_reg, prev_reg);
        end
        if (req_valid && req_ready) begin
          if (exp_req_q.size() == 0) fail_event("req_unexpected");
          else begin
            chk("req_reg", req_reg, exp_req_q.pop_front());
            chk("req_dev", req_dev, 7'h53);
          end
        end
        prev_hold = req_valid && !req_ready;
        prev_reg  = req_reg;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    if (a == 3'd0) begin m_ovf = 0; m_err = 0; m_missed = 0; end
    if (a == 3'd1) begin m_en = d[0]; m_irq_en = d[1]; end
  endtask

  task automatic rd(input string name, input logic [2:0] a);
    logic [15:0] e;
    case (a)
      3'd0: e = exp_status();
      3'd1: e = {14'b0, m_irq_en, m_en};
      3'd2: e = (model_q.size() != 0) ? model_q.pop_front() : 16'h0000;
      3'd3: e = 16'(model_q.size());
      default: e = 16'h0000;
    endcase
    exp_rd_q.push_back(e);
    exp_rd_name.push_back(name);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic chk_irq();
    chk("irq", irq, m_irq_en & ((model_q.size() >= 3) | m_ovf | m_err));
  endtask

  task automatic serve_byte(input int hold, input logic [7:0] d, input bit e, input int lat, input bit pop);
    int n = 0;
    req_ready = (hold == 0);
    while (!req_valid && n < 50) begin @(negedge clk); n++; end
    if (!req_valid) begin
      chk("req_valid_timeout", req_valid, 1);
      req_ready = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    repeat (lat) @(negedge clk);
    resp_valid = 1'b1; resp_data = d; resp_err = e;
    if (pop) begin
      exp_rd_q.push_back((model_q.size() != 0) ? model_q.pop_front() : 16'h0000);
      exp_rd_name.push_back("pop_in_push_cycle");
      address = 3'd2; chipselect = 1'b1; read = 1'b1;
    end
    @(negedge clk);
    resp_valid = 1'b0; resp_err = 1'b0;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic do_sample(input logic [47:0] bytes, input int err_idx, input int hold,
                           input bit strobe, input bit missed_tick, input bit pop_last);
    int  last;
    bit  room;
    last = (err_idx >= 0) ? err_idx : 5;
    room = (DEPTH - model_q.size()) >= 3;
    for (int k = 0; k <= last; k++) exp_req_q.push_back(8'h32 + 8'(k));
    if (strobe) wr(3'd1, {13'b0, 1'b1, m_irq_en, m_en});
    else begin tick = 1'b1; @(negedge clk); tick = 1'b0; end
    for (int k = 0; k <= last; k++) begin
      if (missed_tick && k == 2) begin
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        m_missed = 1;
      end
      serve_byte((k == 0) ? hold : 0, bytes[8*k +: 8], k == err_idx, $urandom_range(0, 3),
                 pop_last && (k == 5) && (err_idx < 0));
    end
    if (err_idx >= 0) m_err = 1;
    else if (room) begin
      model_q.push_back(bytes[15:0]);
      model_q.push_back(bytes[31:16]);
      model_q.push_back(bytes[47:32]);
    end else m_ovf = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    while (model_q.size() != 0) rd("fifo_data", 3'd2);
    rd("level_drained", 3'd3);
  endtask

  function automatic logic [47:0] rnd_bytes();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin : stim
    int n;
    int err_idx;
    bit pl;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_readdata", readdata, 16'h0000);
    chk("reset_irq", irq, 0);
    chk("reset_req_valid", req_valid, 0);
    rd("reset_status", 3'd0);
    rd("reset_level", 3'd3);
    rd("reset_ctrl", 3'd1);
    rd("empty_fifo_read", 3'd2);
    rd("empty_level", 3'd3);

    // Known-byte sample
    wr(3'd1, 16'h0001);
    do_sample(48'h060504030201, -1, 0, 0, 0, 0);
    rd("level_3", 3'd3);
    rd("fifo_x", 3'd2);
    rd("fifo_y", 3'd2);
    rd("fifo_z", 3'd2);
    rd("level_0", 3'd3);

    // Backpressure on the first request
    do_sample(rnd_bytes(), -1, 10, 0, 0, 0);
    drain();

    // Error on the third byte, then a clean sample
    do_sample(rnd_bytes(), 2, 0, 0, 0, 0);
    rd("status_err", 3'd0);
    rd("level_after_err", 3'd3);
    do_sample(rnd_bytes(), -1, 0, 0, 0, 0);
    drain();
    wr(3'd0, 16'h0000);

    // Missed tick while busy, then clear
    do_sample(rnd_bytes(), -1, 0, 0, 1, 0);
    chk("no_extra_req", req_valid, 0);
    rd("status_missed", 3'd0);
    wr(3'd0, 16'h0000);
    rd("status_cleared", 3'd0);
    drain();

    // Start strobe via ctrl write; bit2 reads back as 0
    do_sample(rnd_bytes(), -1, 0, 1, 0, 0);
    rd("ctrl_strobe_reads_0", 3'd1);
    drain();

    // Randomized samples
    wr(3'd1, 16'h0003);
    for (int i = 0; i < 25; i++) begin
      err_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      pl = (err_idx < 0) && (model_q.size() >= 1) && (model_q.size() <= 13) && ($urandom_range(0, 1) == 1);
      do_sample(rnd_bytes(), err_idx, $urandom_range(0, 3), $urandom_range(0, 1) == 1, 0, pl);
      n = $urandom_range(0, 3);
      repeat (n) rd("rand_fifo", 3'd2);
      rd("rand_level", 3'd3);
      rd("rand_status", 3'd0);
      chk_irq();
      if ($urandom_range(0, 3) == 0) wr(3'd0, 16'h0000);
    end
    drain();

    // Overflow: five samples fill 15, sixth is dropped
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0003);
    for (int i = 0; i < 5; i++) do_sample(rnd_bytes(), -1, 0, 0, 0, 0);
    rd("level_15", 3'd3);
    do_sample(rnd_bytes(), -1, 0, 0, 0, 0);
    rd("status_overflow", 3'd0);
    rd("level_still_15", 3'd3);
    chk_irq();
    chk("irq_overflow", irq, 1);
    drain();
    wr(3'd0, 16'h0000);

    // Pop in the push cycle
    do_sample(rnd_bytes(), -1, 0, 0, 0, 0);
    rd("fifo_pre", 3'd2);
    rd("level_2", 3'd3);
    do_sample(rnd_bytes(), -1, 0, 0, 0, 1);
    rd("level_plus2", 3'd3);
    drain();

    // Writes to unmapped addresses are ignored
    wr(3'd5, 16'hFFFF);
    rd("ctrl_after_addr5", 3'd1);
    rd("addr5_reads_0", 3'd5);
    rd("addr7_reads_0", 3'd7);

    // Reset in WAIT, late response ignored
    wr(3'd1, 16'h0001);
    exp_req_q.push_back(8'h32);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    n = 0;
    while (!req_valid && n < 50) begin @(negedge clk); n++; end
    chk("rst_req_seen", req_valid, 1);
    req_ready = 1'b1; @(negedge clk); req_ready = 1'b0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    model_q.delete();
    m_ovf = 0; m_err = 0; m_missed = 0; m_en = 0; m_irq_en = 0;
    resp_valid = 1'b1; resp_data = 8'hAA; @(negedge clk); resp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("req_valid_after_reset", req_valid, 0);
    end
    rd("status_after_reset", 3'd0);
    rd("level_after_reset", 3'd3);
    rd("ctrl_after_reset", 3'd1);

    repeat (3) @(negedge clk);
    chk("exp_req_left", exp_req_q.size(), 0);
    chk("exp_rd_left", exp_rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
